wb_register_file: RTL

WB_REGISTER_FILE -- requirements
Module: wb_register_file

---
 rtl/wb_register_file_if.sv | 29 ++
 rtl/wb_register_file.sv | 78 +++++++
 2 files changed

// File: rtl/wb_register_file_if.sv
// Writeback/read-port bundle between the pipeline and the register file.
// master = pipeline side driving writeback and read indices; slave = register file.
interface wb_register_file_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   RegWrite_WB;
    logic                   MemtoReg_WB;
    logic [31:0]            Read_Data_WB;
    logic [31:0]            ALU_Result_WB;
    logic [4:0]             Write_Register_WB;
    logic [4:0]             Read_Register_1;
    logic [4:0]             Read_Register_2;
    logic [31:0]            Read_Data_1;
    logic [31:0]            Read_Data_2;
    logic [31:0]            Write_Data_WB;
    logic [COUNT_WIDTH-1:0] WB_Count;

    modport master (
        output RegWrite_WB, MemtoReg_WB, Read_Data_WB, ALU_Result_WB,
        output Write_Register_WB, Read_Register_1, Read_Register_2,
        input  Read_Data_1, Read_Data_2, Write_Data_WB, WB_Count
    );

    modport slave (
        input  RegWrite_WB, MemtoReg_WB, Read_Data_WB, ALU_Result_WB,
        input  Write_Register_WB, Read_Register_1, Read_Register_2,
        output Read_Data_1, Read_Data_2, Write_Data_WB, WB_Count
    );
endinterface

// File: rtl/wb_register_file.sv
// 31x32 register file (R0 hard-wired to zero) with writeback mux and saturating commit counter.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback onto the read ports.
module wb_register_file #(
    parameter int COUNT_WIDTH = 32
) (
    input logic              Clk,
    input logic              Reset,
    wb_register_file_if.slave wb
);
    logic [31:0]            write_data;
    logic                   commit;
    logic [31:0]            regs [32];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [31:0]            rd1;
    logic [31:0]            rd2;

    assign write_data = wb.MemtoReg_WB ? wb.Read_Data_WB : wb.ALU_Result_WB;
    // Reset is not folded in here: the async clear already dominates every flop.
    assign commit     = wb.RegWrite_WB && (wb.Write_Register_WB != 5'd0);

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] data_q;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    data_q <= '0;
                end else if (commit && (wb.Write_Register_WB == 5'(gi))) begin
                    data_q <= write_data;
                end
            end

            assign regs[gi] = data_q;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (commit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        rd1 = regs[wb.Read_Register_1];
        rd2 = regs[wb.Read_Register_2];
`ifdef REGFILE_BYPASS_EN
        // commit already excludes R0, so index 0 can never pick up the bypass.
        if (commit && (wb.Write_Register_WB == wb.Read_Register_1)) begin
            rd1 = write_data;
        end
        if (commit && (wb.Write_Register_WB == wb.Read_Register_2)) begin
            rd2 = write_data;
        end
`endif
        if (Reset) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

    assign wb.Read_Data_1   = rd1;
    assign wb.Read_Data_2   = rd2;
    assign wb.Write_Data_WB = write_data;
    assign wb.WB_Count      = count_q;
endmodule
